// File: rtl/sun_pll_ctrl.sv
// sun_pll_ctrl: powers the analog PLL, measures the synchronized feedback count per window, declares lock or retries.
// Define SUN_PLL_CTRL_DBG_EN to expose DELTA (last window delta) and WIN_END (evaluated-window pulse).
module sun_pll_ctrl #(
  parameter int SETTLE_CYC = 64,
  parameter int WIN_CYC    = 32,
  parameter int TOL        = 2,
  parameter int LOCK_CNT   = 4,
  parameter int MAX_WIN    = 16,
  parameter int MAX_RETRY  = 3,
  parameter int OFF_CYC    = 16
) (
  input  logic       CK_REF,
  input  logic       RST_N,
  input  logic       EN,
  input  logic [5:0] FB_GRAY,
  output logic       PWRUP_1V8,
  output logic       LOCK,
  output logic       FAIL,
  output logic [2:0] STATE
`ifdef SUN_PLL_CTRL_DBG_EN
  ,
  output logic [5:0] DELTA,
  output logic       WIN_END
`endif
);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_MEASURE  = 3'd2,
    ST_LOCKED   = 3'd3,
    ST_COOLDOWN = 3'd4,
    ST_FAIL     = 3'd5
  } state_t;

  localparam int TMR_MAX = (SETTLE_CYC > OFF_CYC) ? SETTLE_CYC : OFF_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int WIN_W   = $clog2(WIN_CYC + 1);
  localparam int GOOD_W  = $clog2(LOCK_CNT + 1);
  localparam int BAD_W   = $clog2(MAX_WIN + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [6:0] DELTA_LO = 7'(WIN_CYC - TOL);
  localparam logic [6:0] DELTA_HI = 7'(WIN_CYC + TOL);

  state_t             state, state_nxt;
  logic [5:0]         fb_s1, fb_s2, fb_bin, prev_smp, delta;
  logic [TMR_W-1:0]   tmr;
  logic [WIN_W-1:0]   win_cnt;
  logic [GOOD_W-1:0]  good_cnt;
  logic [BAD_W-1:0]   bad_cnt;
  logic [RETRY_W-1:0] retry_cnt;
  logic               base_pend, win_active, win_end, win_good;
`ifdef SUN_PLL_CTRL_DBG_EN
  logic [5:0]         delta_q;
  logic               win_end_q;
  assign DELTA   = delta_q;
  assign WIN_END = win_end_q;
`endif

  function automatic logic [5:0] gray2bin(input logic [5:0] g);
    logic [5:0] b;
    b[5] = g[5];
    for (int i = 4; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign fb_bin     = gray2bin(fb_s2);
  assign delta      = fb_bin - prev_smp;  // 6-bit subtraction wraps mod 64 like the counter
  assign win_active = ((state == ST_MEASURE) || (state == ST_LOCKED)) && !base_pend;
  assign win_end    = win_active && (win_cnt == WIN_W'(WIN_CYC - 1));
  assign win_good   = ({1'b0, delta} >= DELTA_LO) && ({1'b0, delta} <= DELTA_HI);

  // NOTE: state_nxt gets a default before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    if (!EN) begin
      state_nxt = ST_OFF;
    end else begin
      case (state)
        ST_OFF:      state_nxt = ST_SETTLE;
        ST_SETTLE:   if (tmr == TMR_W'(SETTLE_CYC - 1)) state_nxt = ST_MEASURE;
        ST_MEASURE: begin
          if (win_end) begin
            if (win_good) begin
              if (good_cnt == GOOD_W'(LOCK_CNT - 1)) state_nxt = ST_LOCKED;
            end else if (bad_cnt == BAD_W'(MAX_WIN - 1)) begin
              state_nxt = (retry_cnt == RETRY_W'(MAX_RETRY - 1)) ? ST_FAIL : ST_COOLDOWN;
            end
          end
        end
        ST_LOCKED:   if (win_end && !win_good) state_nxt = ST_MEASURE;
        ST_COOLDOWN: if (tmr == TMR_W'(OFF_CYC - 1)) state_nxt = ST_SETTLE;
        ST_FAIL:     state_nxt = ST_FAIL;
        default:     state_nxt = ST_OFF;
      endcase
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CK_REF) begin
    if (!RST_N) begin
      state     <= ST_OFF;
      fb_s1     <= '0;
      fb_s2     <= '0;
      prev_smp  <= '0;
      tmr       <= '0;
      win_cnt   <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      retry_cnt <= '0;
      base_pend <= 1'b0;
      PWRUP_1V8 <= 1'b0;
      LOCK      <= 1'b0;
      FAIL      <= 1'b0;
`ifdef SUN_PLL_CTRL_DBG_EN
      delta_q   <= '0;
      win_end_q <= 1'b0;
`endif
    end else begin
      fb_s1     <= FB_GRAY;
      fb_s2     <= fb_s1;
      state     <= state_nxt;
      PWRUP_1V8 <= (state_nxt == ST_SETTLE) || (state_nxt == ST_MEASURE) || (state_nxt == ST_LOCKED);
      LOCK      <= (state_nxt == ST_LOCKED);
      FAIL      <= (state_nxt == ST_FAIL);
`ifdef SUN_PLL_CTRL_DBG_EN
      win_end_q <= EN && win_end;
      if (EN && win_end) delta_q <= delta;
`endif
      if (!EN) begin
        tmr       <= '0;
        win_cnt   <= '0;
        good_cnt  <= '0;
        bad_cnt   <= '0;
        retry_cnt <= '0;
        base_pend <= 1'b0;
      end else begin
        if (state_nxt != state) tmr <= '0;
        else if ((state == ST_SETTLE) || (state == ST_COOLDOWN)) tmr <= tmr + 1'b1;

        if ((state == ST_SETTLE) && (state_nxt == ST_MEASURE)) begin
          base_pend <= 1'b1;
        end else if ((state == ST_MEASURE) && base_pend) begin
          prev_smp  <= fb_bin;
          win_cnt   <= '0;
          base_pend <= 1'b0;
        end else if (win_active) begin
          if (win_end) begin
            prev_smp <= fb_bin;
            win_cnt  <= '0;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end

        // Entering MEASURE (fresh attempt or lost lock) starts both streaks from zero.
        if ((state_nxt == ST_MEASURE) && (state != ST_MEASURE)) begin
          good_cnt <= '0;
          bad_cnt  <= '0;
        end else if ((state == ST_MEASURE) && win_end) begin
          if (win_good) begin
            good_cnt <= good_cnt + 1'b1;
            bad_cnt  <= '0;
          end else begin
            good_cnt <= '0;
            bad_cnt  <= bad_cnt + 1'b1;
          end
        end

        if ((state == ST_MEASURE) && (state_nxt == ST_LOCKED)) retry_cnt <= '0;
        else if ((state == ST_MEASURE) && ((state_nxt == ST_COOLDOWN) || (state_nxt == ST_FAIL)))
          retry_cnt <= retry_cnt + 1'b1;
      end
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_sun_pll_ctrl.sv
// Directed bench for sun_pll_ctrl: lock timing, tolerance edges, relock, reset, EN priority, retry/fail.
module tb_sun_pll_ctrl;

  logic       CK_REF;
  logic       RST_N;
  logic       EN;
  logic [5:0] FB_GRAY;
  logic       PWRUP_1V8, LOCK, FAIL;
  logic [2:0] STATE;
`ifdef SUN_PLL_CTRL_DBG_EN
  logic [5:0] DELTA;
  logic       WIN_END;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int ecnt     = 0;
  int base     = 0;
  int fb_rate  = 32;  // feedback counts per 32 reference cycles
  int fb_acc   = 0;
  logic [5:0] fb_cnt = '0;

  sun_pll_ctrl dut (
    .CK_REF    (CK_REF),
    .RST_N     (RST_N),
    .EN        (EN),
    .FB_GRAY   (FB_GRAY),
    .PWRUP_1V8 (PWRUP_1V8),
    .LOCK      (LOCK),
    .FAIL      (FAIL),
    .STATE     (STATE)
`ifdef SUN_PLL_CTRL_DBG_EN
    ,
    .DELTA     (DELTA),
    .WIN_END   (WIN_END)
`endif
  );

  initial begin
    CK_REF = 1'b0;
    forever #5 CK_REF = ~CK_REF;
  end

  // Feedback counter: fractional accumulator gives exactly fb_rate counts over any 32 consecutive cycles.
  initial begin
    FB_GRAY = '0;
    forever begin
      @(posedge CK_REF);
      ecnt++;
      #2;
      fb_acc += fb_rate;
      fb_cnt = fb_cnt + 6'(fb_acc / 32);
      fb_acc = fb_acc % 32;
      FB_GRAY = fb_cnt ^ (fb_cnt >> 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {PWRUP_1V8, LOCK, FAIL, STATE};
  endfunction

  function automatic logic [5:0] xo(input logic pw, input logic lk, input logic fl, input logic [2:0] st);
    return {pw, lk, fl, st};
  endfunction

  // Cycle k of a run: the negedge after the k-th rising edge counted from the first edge that sees EN=1.
  task automatic start();
    base = ecnt;
  endtask

  task automatic at(input int k);
    while (ecnt - base - 1 < k) @(negedge CK_REF);
  endtask

  initial begin
    RST_N = 1'b0;
    EN    = 1'b0;
    repeat (3) @(negedge CK_REF);
    check("reset_outs", outs(), xo(0, 0, 0, 3'd0));

    // Nominal lock, then tolerance edges and rate faults while locked.
    RST_N = 1'b1;
    EN    = 1'b1;
    start();
    at(0);   check("settle_entry",  outs(), xo(1, 0, 0, 3'd1));
    at(63);  check("settle_last",   outs(), xo(1, 0, 0, 3'd1));
    at(64);  check("measure_entry", outs(), xo(1, 0, 0, 3'd2));
    at(190); fb_rate = 34;
    at(192); check("pre_lock",      outs(), xo(1, 0, 0, 3'd2));
    at(193); check("lock_at_194",   outs(), xo(1, 1, 0, 3'd3));
`ifdef SUN_PLL_CTRL_DBG_EN
    check("delta_nominal", DELTA, 32);
    check("win_end_pulse", WIN_END, 1);
    at(194); check("win_end_clear", WIN_END, 0);
`endif
    at(222); fb_rate = 30;
    at(225); check("tol_34_good",   outs(), xo(1, 1, 0, 3'd3));
`ifdef SUN_PLL_CTRL_DBG_EN
    check("delta_34", DELTA, 34);
`endif
    at(254); fb_rate = 35;
    at(257); check("tol_30_good",   outs(), xo(1, 1, 0, 3'd3));
`ifdef SUN_PLL_CTRL_DBG_EN
    check("delta_30", DELTA, 30);
`endif
    at(286); fb_rate = 32;
    at(288); check("pre_35_locked", outs(), xo(1, 1, 0, 3'd3));
    at(289); check("tol_35_bad",    outs(), xo(1, 0, 0, 3'd2));
`ifdef SUN_PLL_CTRL_DBG_EN
    check("delta_35", DELTA, 35);
`endif
    at(414); fb_rate = 29;
    at(416); check("relock1_pre",   outs(), xo(1, 0, 0, 3'd2));
    at(417); check("relock1",       outs(), xo(1, 1, 0, 3'd3));
    at(446); fb_rate = 32;
    at(449); check("tol_29_bad",    outs(), xo(1, 0, 0, 3'd2));
`ifdef SUN_PLL_CTRL_DBG_EN
    check("delta_29", DELTA, 29);
`endif
    at(574); fb_rate = 40;
    at(576); check("relock2_pre",   outs(), xo(1, 0, 0, 3'd2));
    at(577); check("relock2",       outs(), xo(1, 1, 0, 3'd3));
    at(606); fb_rate = 32;
    at(608); check("rate40_pre",    outs(), xo(1, 1, 0, 3'd3));
    at(609); check("rate40_drop",   outs(), xo(1, 0, 0, 3'd2));
`ifdef SUN_PLL_CTRL_DBG_EN
    check("delta_40", DELTA, 40);
`endif
    at(736); check("relock3_pre",   outs(), xo(1, 0, 0, 3'd2));
    at(737); check("relock3",       outs(), xo(1, 1, 0, 3'd3));
    at(769); check("wrap_hold1",    outs(), xo(1, 1, 0, 3'd3));
`ifdef SUN_PLL_CTRL_DBG_EN
    check("delta_wrap", DELTA, 32);
`endif
    at(801); check("wrap_hold2",    outs(), xo(1, 1, 0, 3'd3));

    // One-cycle reset while locked.
    at(810); RST_N = 1'b0;
    at(811); check("reset_midrun",  outs(), xo(0, 0, 0, 3'd0));
    RST_N = 1'b1;
    start();
    at(0);   check("restart_settle", outs(), xo(1, 0, 0, 3'd1));
`ifdef SUN_PLL_CTRL_DBG_EN
    at(161); check("win_end_3rd", WIN_END, 1);
`endif
    at(192); check("en_drop_pre",   outs(), xo(1, 0, 0, 3'd2));
    EN = 1'b0;
    at(193); check("en_drop_4th",   outs(), xo(0, 0, 0, 3'd0));
`ifdef SUN_PLL_CTRL_DBG_EN
    check("win_end_ignored", WIN_END, 0);
`endif

    // Frozen feedback: three failed attempts then FAIL, released by EN=0.
    at(195); fb_rate = 0; EN = 1'b1;
    start();
    at(0);    check("fz_settle",     outs(), xo(1, 0, 0, 3'd1));
    at(576);  check("fz_meas1",      outs(), xo(1, 0, 0, 3'd2));
    at(577);  check("fz_cool1",      outs(), xo(0, 0, 0, 3'd4));
    at(592);  check("fz_cool1_last", outs(), xo(0, 0, 0, 3'd4));
    at(593);  check("fz_settle2",    outs(), xo(1, 0, 0, 3'd1));
    at(1170); check("fz_cool2",      outs(), xo(0, 0, 0, 3'd4));
    at(1762); check("fz_meas3",      outs(), xo(1, 0, 0, 3'd2));
    at(1763); check("fz_fail",       outs(), xo(0, 0, 1, 3'd5));
    at(1800); check("fz_fail_hold",  outs(), xo(0, 0, 1, 3'd5));
    EN = 1'b0;
    at(1801); check("fz_off",        outs(), xo(0, 0, 0, 3'd0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sun_pll_ctrl.md
SUN_PLL_CTRL -- requirements
Module: sun_pll_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, 64: CK_REF cycles PWRUP_1V8 is held high before lock measurement starts.
REQ-002 Parameter WIN_CYC, 32: measurement window length in CK_REF cycles; legal range 8..48.
REQ-003 Parameter TOL, 2: allowed absolute deviation of the feedback count per window from WIN_CYC.
REQ-004 Parameter LOCK_CNT, 4: consecutive good windows needed to declare lock.
REQ-005 Parameter MAX_WIN, 16: consecutive bad windows in MEASURE before an attempt is declared failed.
REQ-006 Parameter MAX_RETRY, 3: failed attempts before entering FAIL.
REQ-007 Parameter OFF_CYC, 16: CK_REF cycles PWRUP_1V8 is held low between attempts.
REQ-008 CK_REF  in  1  reference clock; the only clock, all logic on its rising edge.
REQ-009 RST_N  in  1  reset, synchronous, active-low.
REQ-010 EN  in  1  request PLL on; level-sensitive.
REQ-011 FB_GRAY  in  6  Gray-coded free-running counter of CK_FB rising edges, asynchronous to CK_REF.
REQ-012 PWRUP_1V8  out  1  PLL power-up, drives the analog PLL and its kick generator.
REQ-013 LOCK  out  1  PLL locked.
REQ-014 FAIL  out  1  lock not achieved after MAX_RETRY attempts.
REQ-015 STATE  out  3  current state encoding: OFF=0, SETTLE=1, MEASURE=2, LOCKED=3, COOLDOWN=4, FAIL=5.

Function
REQ-016 FB_GRAY SHALL pass through a two-flop synchronizer, then Gray-to-binary conversion, before any use.
REQ-017 All outputs SHALL be registered and decoded from the registered state: PWRUP_1V8=1 in SETTLE/MEASURE/LOCKED, LOCK=1 only in LOCKED, FAIL=1 only in FAIL.
REQ-018 OFF: EN=1 -> SETTLE next cycle with the timer cleared.
REQ-019 SETTLE: after exactly SETTLE_CYC cycles in the state -> MEASURE; good-window count and bad-window count cleared.
REQ-020 On the first MEASURE cycle the synchronized binary count SHALL be captured as the baseline; a window then ends every WIN_CYC cycles.
REQ-021 At each window end: delta = (current - previous sample) mod 64; previous sample := current; window good iff |delta - WIN_CYC| <= TOL.
REQ-022 MEASURE: good window -> good count +1, bad count cleared; bad window -> good count cleared, bad count +1.
REQ-023 MEASURE: good count reaching LOCK_CNT -> LOCKED next cycle; retry count cleared.
REQ-024 MEASURE: bad count reaching MAX_WIN -> retry count +1; if the new retry count equals MAX_RETRY -> FAIL, else -> COOLDOWN.
REQ-025 LOCKED: windows continue without restarting; one bad window -> MEASURE next cycle, LOCK=0, counts cleared, previous sample kept.
REQ-026 COOLDOWN: after exactly OFF_CYC cycles -> SETTLE.
REQ-027 FAIL: held until EN=0.
REQ-028 EN=0 in any state -> OFF next cycle; all counters, including the retry count, cleared; EN=0 takes priority over every other transition in the same cycle.
REQ-029 A window end coinciding with EN falling SHALL be ignored.

Reset
REQ-030 RST_N=0 at a rising edge: state OFF, all counters, samples and synchronizer flops 0; PWRUP_1V8=LOCK=FAIL=0, STATE=0 from the next cycle.
REQ-031 Reset asserted mid-operation SHALL take priority over every transition; after release the block SHALL restart from OFF.

Configuration
REQ-032 Macro SUN_PLL_CTRL_DBG_EN defined: extra outputs DELTA (out, 6 bits, last window delta, reset 0) and WIN_END (out, 1 bit, one-cycle pulse on the cycle after each evaluated window).
REQ-033 Macro SUN_PLL_CTRL_DBG_EN undefined: these ports and their logic are absent; all other behaviour is identical.

Verification
REQ-034 Defaults; EN high at cycle 0; FB increments once per CK_REF cycle -> PWRUP_1V8=1 at cycle 1, STATE=2 at cycle 65, LOCK=1 at cycle 194.
REQ-035 FB frozen -> COOLDOWN after 16 bad windows; PWRUP_1V8 low for 16 cycles per retry; FAIL=1 and PWRUP_1V8=0 after the 3rd failure; EN=0 -> OFF and FAIL=0 next cycle.
REQ-036 Locked, then FB rate changed to 40 per window -> LOCK=0 and STATE=2 one cycle after that window end; rate restored -> relock after 4 good windows.
REQ-037 Tolerance edges: window deltas 34 and 30 are good; 35 and 29 are bad; verified with the debug macro on via DELTA.
REQ-038 FB_GRAY wraps 63->0 inside a window at nominal rate -> delta=32, window good, LOCK is not disturbed.
REQ-039 RST_N low for one cycle while LOCKED -> all outputs 0 next cycle; EN=0 coinciding with a good 4th window end -> OFF, no lock asserted.
